main_memory_responder: RTL

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

---
 rtl/mem_pkg.sv | 15 +
 rtl/main_memory_responder_if.sv | 23 ++
 rtl/mem_word_ram.sv | 31 +++
 rtl/main_memory_responder.sv | 86 ++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the main-memory responder and its word store.
package mem_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int WORD_IDX_W = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache-to-memory request/response bus; master is the cache, slave the responder.
interface main_memory_responder_if;
    import mem_pkg::*;

    logic              req;
    logic              write_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] write_data_in;
    logic              done;
    logic              busy;
    logic [DATA_W-1:0] read_data_out;

    modport master (
        output req, write_in, addr_in, write_data_in,
        input  done, busy, read_data_out
    );

    modport slave (
        input  req, write_in, addr_in, write_data_in,
        output done, busy, read_data_out
    );

endinterface

// File: rtl/mem_word_ram.sv
// Word store: one synchronous write port, one registered read port, no reset.
module mem_word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [WORD_IDX_W-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int RAW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;
    logic [RAW-1:0]    widx;

    // Indices beyond the array fold back onto it.
    assign widx = RAW'(32'(addr_i) % 32'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (we_i) mem_q[widx] <= wdata_i;
        if (re_i) rdata_q     <= mem_q[widx];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency memory responder: latch a request, wait LATENCY cycles, pulse done.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    main_memory_responder_if.slave  bus
);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_q;
    logic [WORD_IDX_W-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  rvalid_q;
    logic                  fire;
    logic [DATA_W-1:0]     ram_rdata;
    logic [1:0]            unused_byte_ofs;

    assign unused_byte_ofs = bus.addr_in[1:0];

    // The memory access happens on the edge that moves WAIT -> RESP.
    assign fire = (state_q == WAIT) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        wr_q    <= bus.write_in;
                        idx_q   <= bus.addr_in[ADDR_W-1:2];
                        wdata_q <= bus.write_data_in;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= RESP;
                        if (!wr_q) rvalid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk     (clk),
        .we_i    (fire & wr_q),
        .re_i    (fire & ~wr_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // The RAM read register holds between reads but has no reset; mask it
    // until the first read since reset has landed.
    assign bus.done          = done_q;
    assign bus.busy          = busy_q;
    assign bus.read_data_out = rvalid_q ? ram_rdata : '0;

endmodule
